// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side FIFO consumer. Pops DATA_W-bit entries and packs
// PACK consecutive entries into one wide word on a valid/ready stream. A flush
// emits a partially filled word with a lane mask.
// Ports:
//   rd_clk, rd_rst        clock, synchronous active-high reset
//   fifo_empty/fifo_rd_en FIFO read handshake; fifo_dout valid one cycle after a pop
//   flush                 single-cycle request to emit a partial word
//   m_data/m_keep/m_valid packed word, lane mask, valid (lane i at [i*DATA_W +: DATA_W])
//   m_ready               downstream accept
//   word_cnt              count of accepted words, wraps
module fifo_rd_packer #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [DATA_W-1:0]        fifo_dout,
  input  logic                     flush,
  output logic [DATA_W*PACK-1:0]   m_data,
  output logic [PACK-1:0]          m_keep,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [15:0]              word_cnt
);

  localparam int unsigned CW = $clog2(PACK + 1);

  typedef enum logic {
    FILL,
    FLUSH
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               filled_q, filled_d;
  logic                        inflight_q, inflight_d;
  logic [PACK-1:0][DATA_W-1:0] lanes_q, lanes_d;
  logic [DATA_W*PACK-1:0]      m_data_q, m_data_d;
  logic [PACK-1:0]             m_keep_q, m_keep_d;
  logic                        m_valid_q, m_valid_d;
  logic [15:0]                 word_cnt_q, word_cnt_d;

  logic [CW-1:0]               filled_cap;
  logic [PACK-1:0]             keep_cap;
  logic                        pop, hs, slot_free, full_now, flush_take, handoff;

  always_comb begin
    hs         = m_valid_q && m_ready;
    slot_free  = !m_valid_q || m_ready;
    // Lane count once this cycle's pending read (if any) has been captured.
    filled_cap = filled_q + CW'(inflight_q);
    pop        = !fifo_empty && (state_q == FILL) && (filled_cap < CW'(PACK)) && !rd_rst;
    full_now   = (filled_cap == CW'(PACK));

    lanes_d = lanes_q;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (inflight_q && (filled_q == CW'(i))) lanes_d[i] = fifo_dout;
    end

    for (int unsigned i = 0; i < PACK; i++) begin
      keep_cap[i] = (CW'(i) < filled_cap);
    end

    // A flush on a completing full word is dropped; the word goes out whole.
    flush_take = flush && (state_q == FILL) && (filled_cap != '0) && !full_now;

    handoff = 1'b0;
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (full_now) begin
          handoff = slot_free;
        end else if (flush_take) begin
          // Hand off immediately when nothing more is coming and the slot is
          // free; otherwise park in FLUSH until both hold.
          if (slot_free && !pop) handoff = 1'b1;
          else                   state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          handoff = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    filled_d   = handoff ? '0 : filled_cap;
    inflight_d = pop;

    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    if (handoff) begin
      m_valid_d = 1'b1;
      m_keep_d  = keep_cap;
      for (int unsigned i = 0; i < PACK; i++) begin
        m_data_d[i*DATA_W +: DATA_W] = keep_cap[i] ? lanes_d[i] : '0;
      end
    end

    word_cnt_d = word_cnt_q + 16'(hs);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q    <= FILL;
      filled_q   <= '0;
      inflight_q <= 1'b0;
      lanes_q    <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_valid_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      filled_q   <= filled_d;
      inflight_q <= inflight_d;
      lanes_q    <= lanes_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_valid_q  <= m_valid_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;
  assign m_valid    = m_valid_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a queue-based FIFO model and an
// expected-word scoreboard.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  typedef struct {
    logic [DW*PK-1:0] data;
    logic [PK-1:0]    keep;
  } word_t;

  logic             rd_clk = 1'b0;
  logic             rd_rst;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [DW-1:0]    fifo_dout;
  logic             flush;
  logic [DW*PK-1:0] m_data;
  logic [PK-1:0]    m_keep;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      word_cnt;

  fifo_rd_packer #(.DATA_W(DW), .PACK(PK)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .word_cnt   (word_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0]    fq[$];
  word_t            exp_q[$];
  int               passed = 0;
  int               total = 0;
  int               fails = 0;
  int               cyc = 0;
  int               pops = 0;
  int               words_seen = 0;
  int               first_pop = -1;
  int               first_valid = -1;
  logic             prev_stall = 1'b0;
  logic [DW*PK-1:0] prev_data;
  logic [PK-1:0]    prev_keep;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input int start, input int n);
    for (int i = 0; i < n; i++) fq.push_back(DW'(start + i));
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic expect_word(input logic [DW*PK-1:0] d, input logic [PK-1:0] k);
    word_t w;
    w.data = d;
    w.keep = k;
    exp_q.push_back(w);
  endtask

  // One clock: observe at negedge, then model the FIFO just after posedge.
  task automatic tick();
    logic  pop_now;
    word_t w;
    @(negedge rd_clk);
    cyc++;
    if (fifo_rd_en) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (fifo_empty) chk("no_pop_when_empty", 64'(fifo_rd_en), 64'd0);
    if (prev_stall) begin
      chk("hold_data", 64'(m_data), 64'(prev_data));
      chk("hold_keep", 64'(m_keep), 64'(prev_keep));
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        fails++;
        $error("FAIL unexpected_word: got %0h expected none", m_data);
      end else begin
        w = exp_q.pop_front();
        chk("sb_data", 64'(m_data), 64'(w.data));
        chk("sb_keep", 64'(m_keep), 64'(w.keep));
      end
      words_seen++;
    end
    prev_stall = m_valid && !m_ready && !rd_rst;
    prev_data  = m_data;
    prev_keep  = m_keep;
    pop_now    = fifo_rd_en;
    @(posedge rd_clk);
    #1;
    if (pop_now && fq.size() > 0) fifo_dout = fq.pop_front();
    fifo_empty = (fq.size() == 0);
    flush = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_words(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && words_seen < n; i++) tick();
    chk(tag, 64'(words_seen), 64'(n));
  endtask

  task automatic do_reset();
    rd_rst = 1'b1;
    ticks(2);
    rd_rst = 1'b0;
    fq.delete();
    exp_q.delete();
    fifo_empty  = 1'b1;
    flush       = 1'b0;
    pops        = 0;
    words_seen  = 0;
    first_pop   = -1;
    first_valid = -1;
    cyc         = 0;
  endtask

  initial begin
    rd_rst     = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    flush      = 1'b0;
    m_ready    = 1'b0;

    // Reset with a non-empty FIFO.
    fq.push_back(8'h55);
    fifo_empty = 1'b0;
    tick();
    chk("rst_rd_en_c1", 64'(fifo_rd_en), 64'd0);
    tick();
    chk("rst_rd_en_c2", 64'(fifo_rd_en), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_keep", 64'(m_keep), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    chk("rst_pops", 64'(pops), 64'd0);
    do_reset();

    // Streaming.
    m_ready = 1'b1;
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    load(1, 8);
    wait_words("stream_words", 2, 40);
    chk("stream_latency", 64'(first_valid - first_pop), 64'd5);
    chk("stream_pops", 64'(pops), 64'd8);
    chk("stream_word_cnt", 64'(word_cnt), 64'd2);
    do_reset();

    // Backpressure.
    m_ready = 1'b0;
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h08070605, 4'hF);
    load(1, 8);
    ticks(30);
    chk("bp_pops", 64'(pops), 64'd8);
    chk("bp_valid", 64'(m_valid), 64'd1);
    chk("bp_data", 64'(m_data), 64'h04030201);
    chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("bp_word_cnt0", 64'(word_cnt), 64'd0);
    m_ready = 1'b1;
    chk("bp_rd_en_hs", 64'(fifo_rd_en), 64'd0);
    tick();
    chk("bp_next_valid", 64'(m_valid), 64'd1);
    chk("bp_next_data", 64'(m_data), 64'h08070605);
    chk("bp_next_keep", 64'(m_keep), 64'hF);
    tick();
    chk("bp_word_cnt", 64'(word_cnt), 64'd2);
    chk("bp_valid_drop", 64'(m_valid), 64'd0);
    do_reset();

    // Partial flush.
    m_ready = 1'b1;
    expect_word(32'h00CCBBAA, 4'b0111);
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    fq.push_back(8'hCC);
    fifo_empty = 1'b0;
    ticks(8);
    chk("pf_no_valid", 64'(m_valid), 64'd0);
    flush = 1'b1;
    tick();
    chk("pf_valid", 64'(m_valid), 64'd1);
    chk("pf_data", 64'(m_data), 64'h00CCBBAA);
    chk("pf_keep", 64'(m_keep), 64'b0111);
    tick();
    chk("pf_word_cnt", 64'(word_cnt), 64'd1);
    do_reset();

    // Flush in the capture-pending cycle.
    m_ready = 1'b1;
    expect_word(32'h00000011, 4'b0001);
    fq.push_back(8'h11);
    fifo_empty = 1'b0;
    tick();
    chk("fi_popped", 64'(pops), 64'd1);
    flush = 1'b1;
    tick();
    chk("fi_valid", 64'(m_valid), 64'd1);
    chk("fi_data", 64'(m_data), 64'h00000011);
    chk("fi_keep", 64'(m_keep), 64'b0001);
    ticks(3);
    chk("fi_pops", 64'(pops), 64'd1);
    chk("fi_word_cnt", 64'(word_cnt), 64'd1);
    do_reset();

    // Flush parked behind an occupied output slot.
    m_ready = 1'b0;
    expect_word(32'h04030201, 4'hF);
    expect_word(32'h00000605, 4'b0011);
    load(1, 6);
    ticks(12);
    flush = 1'b1;
    tick();
    load(8'h77, 1);
    ticks(3);
    chk("fw_no_pop", 64'(pops), 64'd6);
    m_ready = 1'b1;
    tick();
    chk("fw_valid", 64'(m_valid), 64'd1);
    chk("fw_data", 64'(m_data), 64'h00000605);
    chk("fw_keep", 64'(m_keep), 64'b0011);
    tick();
    chk("fw_word_cnt", 64'(word_cnt), 64'd2);
    do_reset();

    // Reset mid-operation.
    m_ready = 1'b0;
    load(1, 6);
    ticks(12);
    chk("rm_valid_before", 64'(m_valid), 64'd1);
    rd_rst = 1'b1;
    tick();
    rd_rst = 1'b0;
    exp_q.delete();
    chk("rm_valid", 64'(m_valid), 64'd0);
    chk("rm_word_cnt", 64'(word_cnt), 64'd0);
    chk("rm_data", 64'(m_data), 64'd0);
    words_seen = 0;
    m_ready = 1'b1;
    expect_word(32'h04030201, 4'hF);
    load(1, 4);
    wait_words("rm_words", 1, 20);
    chk("rm_word_cnt_after", 64'(word_cnt), 64'd1);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
